merge_pair_node: RTL and testbench

Two-input merge cell of the parallel merge-sort tree. It buffers two descending-sorted input streams in small synchronous FIFOs, compares their head words every cycle, and emits the larger head as a one-word-per-cycle descending output stream. Leaf instances use DEPTH=1 and sort word pairs. Higher tree levels cascade this cell with DEPTH doubling per level, each node's output feeding one input of the next-level node.

---
 rtl/merge_pkg.sv | 23 ++
 rtl/merge_fifo.sv | 105 ++++++++++
 rtl/merge_pair_node.sv | 109 ++++++++++
 tb/tb_merge_pair_node.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// ---------------------------------------------------------------------------
// merge_pkg
// Shared definitions for the merge-sort tree cells.
//   MERGE_DATA_WIDTH : default word width of every tree node
//   sel_e            : output-mux select encoding (SEL_A = 0, SEL_B = 1)
//   level_depth()    : per-level input FIFO depth, 2**level (leaves are level 0)
// ---------------------------------------------------------------------------
package merge_pkg;

  localparam int MERGE_DATA_WIDTH = 32;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // Each tree level doubles the buffering so a node can absorb a whole
  // sorted run coming from the level beneath it.
  function automatic int level_depth(input int level);
    return 1 << level;
  endfunction

endpackage

// File: rtl/merge_fifo.sv
// ---------------------------------------------------------------------------
// merge_fifo
// Small synchronous FIFO that buffers one input stream of a merge node.
// The head word is presented combinationally; a pop takes effect on the
// rising edge where rd is high. A write into a full FIFO is only accepted
// when the same FIFO is popped in that cycle, otherwise it is dropped.
// There is no write-through path: a word written at edge N becomes the head
// only in the cycle after edge N.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   din    in   write data
//   wr     in   write strobe
//   rd     in   pop strobe (ignored while empty)
//   head   out  word at the read pointer
//   empty  out  FIFO holds 0 entries
//   full   out  FIFO holds DEPTH entries
// ---------------------------------------------------------------------------
module merge_fifo
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = MERGE_DATA_WIDTH,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  // Storage is padded up to a power of two so the pointer width indexes it
  // exactly; pointers still wrap at DEPTH, so the padding is never written
  // outside of reset.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = 1 << PTR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_N];
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  doWrite;
  logic                  doRead;

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign head  = mem_q[rdPtr_q];

  // A pop frees a slot in the same cycle, so a write to a full FIFO is
  // legal exactly when that FIFO is also being popped.
  assign doRead  = rd && !empty;
  assign doWrite = wr && (!full || doRead);

  // Next-state pointers and occupancy; a simultaneous write and pop moves
  // both pointers and leaves the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doWrite) begin
      wrPtr_d = nextPtr(wrPtr_q);
    end
    if (doRead) begin
      rdPtr_d = nextPtr(rdPtr_q);
    end
    case ({doWrite, doRead})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every buffered word and clears storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < MEM_N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doWrite) begin
        mem_q[wrPtr_q] <= din;
      end
    end
  end

endmodule

// File: rtl/merge_pair_node.sv
// ---------------------------------------------------------------------------
// merge_pair_node
// Two-input merge cell of the merge-sort tree. Two descending input streams
// are buffered in merge_fifo instances; every cycle the larger head word
// (unsigned) is popped and emitted, one word per cycle, with no backpressure.
// On equal heads B is popped first.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   a_din     in   write data for FIFO A
//   a_wr      in   write strobe for FIFO A
//   b_din     in   write data for FIFO B
//   b_wr      in   write strobe for FIFO B
//   a_full    out  FIFO A holds DEPTH entries
//   b_full    out  FIFO B holds DEPTH entries
//   a_empty   out  FIFO A holds 0 entries
//   b_empty   out  FIFO B holds 0 entries
//   out_data  out  selected head word, 0 when out_wr is low
//   out_wr    out  out_data valid; feeds the next stage's write strobe
// ---------------------------------------------------------------------------
module merge_pair_node
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = MERGE_DATA_WIDTH,
  parameter int DEPTH      = level_depth(0)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_din,
  input  logic                  a_wr,
  input  logic [DATA_WIDTH-1:0] b_din,
  input  logic                  b_wr,
  output logic                  a_full,
  output logic                  b_full,
  output logic                  a_empty,
  output logic                  b_empty,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wr
);

  logic [DATA_WIDTH-1:0] headA;
  logic [DATA_WIDTH-1:0] headB;
  logic                  rdA;
  logic                  rdB;
  logic                  gt;
  sel_e                  sel;

  merge_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) fifoA (
    .clk   (clk),
    .reset (reset),
    .din   (a_din),
    .wr    (a_wr),
    .rd    (rdA),
    .head  (headA),
    .empty (a_empty),
    .full  (a_full)
  );

  merge_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) fifoB (
    .clk   (clk),
    .reset (reset),
    .din   (b_din),
    .wr    (b_wr),
    .rd    (rdB),
    .head  (headB),
    .empty (b_empty),
    .full  (b_full)
  );

  assign gt = (headA > headB);

  // Pop selection: a lone non-empty FIFO is always drained; with both
  // non-empty the strictly larger A wins, otherwise B (ties pop B).
  // At most one side is popped per cycle.
  always_comb begin
    rdA = 1'b0;
    rdB = 1'b0;
    if (!a_empty && !b_empty) begin
      if (gt) begin
        rdA = 1'b1;
      end else begin
        rdB = 1'b1;
      end
    end else if (!a_empty) begin
      rdA = 1'b1;
    end else if (!b_empty) begin
      rdB = 1'b1;
    end
    sel = rdA ? SEL_A : SEL_B;
  end

  // Output mux; data is forced to zero on idle cycles so downstream never
  // sees a stale head.
  always_comb begin
    out_wr   = rdA | rdB;
    out_data = '0;
    if (out_wr) begin
      out_data = (sel == SEL_A) ? headA : headB;
    end
  end

endmodule

// File: tb/tb_merge_pair_node.sv
// ---------------------------------------------------------------------------
// tb_merge_pair_node
// Bench for merge_pair_node with two instances: a leaf (DEPTH=1) and a
// deeper node (DEPTH=4). Directed table vectors and hand sequences cover the
// named corner cases; a randomized phase compares both instances against a
// queue-level model of the merge rules.
// ---------------------------------------------------------------------------
module tb_merge_pair_node;

  localparam int DW = 32;

  typedef struct {
    logic          aw;
    logic [DW-1:0] ad;
    logic          bw;
    logic [DW-1:0] bd;
    logic          expWr;
    logic [DW-1:0] expData;
    logic          expAE;
    logic          expBE;
    logic          expAF;
    logic          expBF;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          aWr     [2];
  logic          bWr     [2];
  logic [DW-1:0] aDin    [2];
  logic [DW-1:0] bDin    [2];
  logic          aFull   [2];
  logic          bFull   [2];
  logic          aEmpty  [2];
  logic          bEmpty  [2];
  logic          outWr   [2];
  logic [DW-1:0] outData [2];

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: per instance, an ordered list of buffered words.
  logic [DW-1:0] mA [2][4];
  logic [DW-1:0] mB [2][4];
  int            nA [2];
  int            nB [2];
  int            depOf [2];

  vec_t          leafVec [12];
  logic [DW-1:0] seqA [4];
  logic [DW-1:0] seqB [4];
  logic [DW-1:0] seqOut [8];

  always #5 clk = ~clk;

  merge_pair_node #(.DATA_WIDTH(DW), .DEPTH(1)) dutLeaf (
    .clk      (clk),
    .reset    (reset),
    .a_din    (aDin[0]),
    .a_wr     (aWr[0]),
    .b_din    (bDin[0]),
    .b_wr     (bWr[0]),
    .a_full   (aFull[0]),
    .b_full   (bFull[0]),
    .a_empty  (aEmpty[0]),
    .b_empty  (bEmpty[0]),
    .out_data (outData[0]),
    .out_wr   (outWr[0])
  );

  merge_pair_node #(.DATA_WIDTH(DW), .DEPTH(4)) dutDeep (
    .clk      (clk),
    .reset    (reset),
    .a_din    (aDin[1]),
    .a_wr     (aWr[1]),
    .b_din    (bDin[1]),
    .b_wr     (bWr[1]),
    .a_full   (aFull[1]),
    .b_full   (bFull[1]),
    .a_empty  (aEmpty[1]),
    .b_empty  (bEmpty[1]),
    .out_data (outData[1]),
    .out_wr   (outWr[1])
  );

  task automatic checkBit(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic aw, input logic [DW-1:0] ad,
                               input logic bw, input logic [DW-1:0] bd);
    aWr[d]  = aw;
    aDin[d] = ad;
    bWr[d]  = bw;
    bDin[d] = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input int d, input logic ew, input logic [DW-1:0] ed,
                             input logic eae, input logic ebe, input logic eaf, input logic ebf);
    checkBit({tag, " out_wr"},   outWr[d],   ew);
    checkWord({tag, " out_data"}, outData[d], ed);
    checkBit({tag, " a_empty"},  aEmpty[d],  eae);
    checkBit({tag, " b_empty"},  bEmpty[d],  ebe);
    checkBit({tag, " a_full"},   aFull[d],   eaf);
    checkBit({tag, " b_full"},   bFull[d],   ebf);
  endtask

  task automatic doReset();
    applyStimulus(0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1, 1'b0, '0, 1'b0, '0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      nA[d] = 0;
      nB[d] = 0;
    end
  endtask

  // One random cycle on instance d: compare against the model's view of the
  // current buffers, then pick inputs and advance the model by the merge rules.
  task automatic randomStep(input int d);
    logic          popA;
    logic          popB;
    logic [DW-1:0] expD;
    logic          aw;
    logic          bw;
    logic [DW-1:0] ad;
    logic [DW-1:0] bd;
    string         tag;
    popA = (nA[d] > 0) && ((nB[d] == 0) || (mA[d][0] > mB[d][0]));
    popB = (nB[d] > 0) && !popA;
    expD = popA ? mA[d][0] : (popB ? mB[d][0] : '0);
    tag  = $sformatf("rand d%0d", d);
    checkOutput(tag, d, popA | popB, expD, nA[d] == 0, nB[d] == 0,
                nA[d] == depOf[d], nB[d] == depOf[d]);
    aw = ($urandom_range(0, 9) < 6);
    bw = ($urandom_range(0, 9) < 6);
    ad = $urandom_range(0, 15);
    bd = $urandom_range(0, 15);
    applyStimulus(d, aw, ad, bw, bd);
    if (popA) begin
      for (int j = 0; j < 3; j++) mA[d][j] = mA[d][j+1];
      nA[d]--;
    end
    if (popB) begin
      for (int j = 0; j < 3; j++) mB[d][j] = mB[d][j+1];
      nB[d]--;
    end
    if (aw && nA[d] < depOf[d]) begin
      mA[d][nA[d]] = ad;
      nA[d]++;
    end
    if (bw && nB[d] < depOf[d]) begin
      mB[d][nB[d]] = bd;
      nB[d]++;
    end
  endtask

  initial begin
    depOf[0] = 1;
    depOf[1] = 4;
    nA[0] = 0; nA[1] = 0; nB[0] = 0; nB[1] = 0;

    // Leaf vectors: {aw, ad, bw, bd, expWr, expData, aEmpty, bEmpty, aFull, bFull}
    leafVec[0]  = '{1'b1, 32'd5,  1'b1, 32'd9,  1'b1, 32'd9,  1'b0, 1'b0, 1'b1, 1'b1};
    leafVec[1]  = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b1, 32'd5,  1'b0, 1'b1, 1'b1, 1'b0};
    leafVec[2]  = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    leafVec[3]  = '{1'b1, 32'd7,  1'b1, 32'd7,  1'b1, 32'd7,  1'b0, 1'b0, 1'b1, 1'b1};
    leafVec[4]  = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b1, 32'd7,  1'b0, 1'b1, 1'b1, 1'b0};
    leafVec[5]  = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    leafVec[6]  = '{1'b1, 32'd3,  1'b0, 32'd0,  1'b1, 32'd3,  1'b0, 1'b1, 1'b1, 1'b0};
    leafVec[7]  = '{1'b1, 32'd8,  1'b0, 32'd0,  1'b1, 32'd8,  1'b0, 1'b1, 1'b1, 1'b0};
    leafVec[8]  = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    leafVec[9]  = '{1'b1, 32'd50, 1'b1, 32'd10, 1'b1, 32'd50, 1'b0, 1'b0, 1'b1, 1'b1};
    leafVec[10] = '{1'b0, 32'd0,  1'b1, 32'd20, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b1};
    leafVec[11] = '{1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b0};

    seqA   = '{32'd40, 32'd30, 32'd20, 32'd10};
    seqB   = '{32'd35, 32'd25, 32'd15, 32'd5};
    seqOut = '{32'd40, 32'd35, 32'd30, 32'd25, 32'd20, 32'd15, 32'd10, 32'd5};

    reset = 1'b0;
    applyStimulus(0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);

    // Reset state, then 10 idle cycles after release on both instances.
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("in reset d%0d", d), d, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("idle c%0d d%0d", c, d), d, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
    end

    // Leaf pair, tie, full-with-pop and full-drop vectors on the DEPTH=1 node.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, leafVec[i].aw, leafVec[i].ad, leafVec[i].bw, leafVec[i].bd);
      tick();
      checkOutput($sformatf("leaf v%0d", i), 0, leafVec[i].expWr, leafVec[i].expData,
                  leafVec[i].expAE, leafVec[i].expBE, leafVec[i].expAF, leafVec[i].expBF);
    end
    applyStimulus(0, 1'b0, '0, 1'b0, '0);

    // DEPTH=4 merge of two descending runs: 8 consecutive outputs, then idle.
    for (int k = 0; k < 8; k++) begin
      if (k < 4) applyStimulus(1, 1'b1, seqA[k], 1'b1, seqB[k]);
      else       applyStimulus(1, 1'b0, '0, 1'b0, '0);
      tick();
      checkBit($sformatf("merge4 k%0d out_wr", k), outWr[1], 1'b1);
      checkWord($sformatf("merge4 k%0d out_data", k), outData[1], seqOut[k]);
    end
    tick();
    checkBit("merge4 drained out_wr", outWr[1], 1'b0);
    checkBit("merge4 drained a_empty", aEmpty[1], 1'b1);
    checkBit("merge4 drained b_empty", bEmpty[1], 1'b1);

    // Reset mid-stream with three words buffered on the DEPTH=4 node.
    applyStimulus(1, 1'b1, 32'd100, 1'b1, 32'd200);
    tick();
    applyStimulus(1, 1'b1, 32'd90, 1'b1, 32'd190);
    tick();
    applyStimulus(1, 1'b0, '0, 1'b0, '0);
    checkBit("midrst pre out_wr", outWr[1], 1'b1);
    checkWord("midrst pre out_data", outData[1], 32'd190);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst async", 1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(1, 1'b1, 32'd11, 1'b1, 32'd12);
    tick();
    applyStimulus(1, 1'b0, '0, 1'b0, '0);
    checkWord("midrst after 1", outData[1], 32'd12);
    tick();
    checkWord("midrst after 2", outData[1], 32'd11);
    tick();
    checkBit("midrst after idle", outWr[1], 1'b0);

    // Randomized phase against the model, both instances in lockstep.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      randomStep(0);
      randomStep(1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
